ll_fifo_drain_arbiter: RTL and testbench

Downstream drain stage for `linked_list_fifo`. Each cycle it picks one non-empty logical FIFO by masked round-robin and drives the shared buffer's `pop`/`pop_sel`. It captures the popped word and its queue ID into a 2-entry output buffer, which a single consumer drains over a valid/ready handshake. It never pops an empty queue, which satisfies the shared buffer's pop-on-empty environment constraint by construction.

---
 rtl/ll_fifo_drain_arbiter.sv | 147 ++++++++++++++
 tb/tb_ll_fifo_drain_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_fifo_drain_arbiter.sv
// ll_fifo_drain_arbiter: drains the logical queues of linked_list_fifo.
// Each cycle the first eligible queue after the last grant (masked round-robin)
// is popped, and the popped word plus its queue ID is captured into a 2-entry
// output buffer that one consumer drains over valid/ready. The pop decision
// never looks at out_ready, so no combinational path runs from the consumer
// back to the shared buffer.

module ll_fifo_drain_arbiter #(
    parameter int WIDTH     = 4,
    parameter int NUM_FIFOS = 4,
    parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [WIDTH-1:0]     data_out,
    input  logic [NUM_FIFOS-1:0] mask,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_qid,
    output logic [15:0]          pop_total
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_FIFOS - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_ONE  = SEL_WIDTH'(1);

    logic [NUM_FIFOS-1:0] elig_s;
    logic [SEL_WIDTH-1:0] cand_s;
    logic [SEL_WIDTH-1:0] sel_s;
    logic                 found_s;
    logic                 pop_s;
    logic                 deq_s;

    logic [SEL_WIDTH-1:0] last_r;
    logic [1:0]           occ_r;
    logic                 wr_ptr_r;
    logic                 rd_ptr_r;
    logic [15:0]          pop_total_r;
    logic [WIDTH-1:0]     buf_data_r [2];
    logic [SEL_WIDTH-1:0] buf_qid_r  [2];

    assign elig_s = ~empty & mask;

    // Round-robin search: walk last+1, last+2, ... with an explicit wrap so
    // codes at or above NUM_FIFOS are never visited; first eligible wins.
    always_comb begin
        cand_s  = last_r;
        sel_s   = last_r;
        found_s = 1'b0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            if (cand_s == LAST_IDX) begin
                cand_s = '0;
            end else begin
                cand_s = cand_s + SEL_ONE;
            end
            if (!found_s && elig_s[cand_s]) begin
                sel_s   = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign pop_s     = found_s & (occ_r < 2'd2);
    assign deq_s     = out_valid & out_ready;
    assign pop       = pop_s;
    assign pop_sel   = sel_s;
    assign out_valid = (occ_r != 2'd0);
    assign out_data  = buf_data_r[rd_ptr_r];
    assign out_qid   = buf_qid_r[rd_ptr_r];
    assign pop_total = pop_total_r;

    // Control state: arbitration pointer, buffer pointers, occupancy, pop count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r      <= LAST_IDX;
            occ_r       <= 2'd0;
            wr_ptr_r    <= 1'b0;
            rd_ptr_r    <= 1'b0;
            pop_total_r <= 16'd0;
        end else begin
            if (pop_s) begin
                last_r      <= sel_s;
                wr_ptr_r    <= ~wr_ptr_r;
                pop_total_r <= pop_total_r + 16'd1;
            end
            if (deq_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({pop_s, deq_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Output buffer storage: the popped word and its queue ID land at the write pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_data_r[0] <= '0;
            buf_data_r[1] <= '0;
            buf_qid_r[0]  <= '0;
            buf_qid_r[1]  <= '0;
        end else if (pop_s) begin
            buf_data_r[wr_ptr_r] <= data_out;
            buf_qid_r[wr_ptr_r]  <= sel_s;
        end
    end

    ll_fifo_drain_arbiter_chk #(
        .NUM_FIFOS (NUM_FIFOS),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .empty   (empty),
        .pop     (pop_s),
        .pop_sel (sel_s),
        .occ     (occ_r)
    );

endmodule

// Safety properties of the drain arbiter: no pop of an empty queue, occupancy
// bounded by the buffer depth, and only legal queue codes on pop_sel.
module ll_fifo_drain_arbiter_chk #(
    parameter int NUM_FIFOS = 4,
    parameter int SEL_WIDTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    input logic [NUM_FIFOS-1:0] empty,
    input logic                 pop,
    input logic [SEL_WIDTH-1:0] pop_sel,
    input logic [1:0]           occ
);

    a_no_empty_pop: assert property (@(posedge clk) disable iff (rst) pop |-> !empty[pop_sel]);
    a_occ_bound:    assert property (@(posedge clk) disable iff (rst) occ <= 2'd2);
    a_sel_legal:    assert property (@(posedge clk) disable iff (rst) int'(pop_sel) < NUM_FIFOS);

endmodule

// File: tb/tb_ll_fifo_drain_arbiter.sv
// Bench for ll_fifo_drain_arbiter: emulates linked_list_fifo queues, keeps a
// queue-based reference model of arbitration and output buffer, and compares
// every cycle; directed scenarios add literal expectations.

module tb_ll_fifo_drain_arbiter;

    localparam int NF = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  empty, data_out, mask, out_data;
    logic [1:0]  pop_sel, out_qid;
    logic        pop, out_valid, out_ready;
    logic [15:0] pop_total;

    logic [2:0]  empty3, mask3;
    logic [3:0]  data3, out_data3;
    logic [1:0]  sel3, qid3;
    logic        pop3, valid3, ready3;
    logic [15:0] total3;

    always #5 clk = ~clk;

    ll_fifo_drain_arbiter #(.WIDTH(4), .NUM_FIFOS(4)) dut (
        .clk(clk), .rst(rst), .empty(empty), .data_out(data_out), .mask(mask),
        .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_qid(out_qid), .pop_total(pop_total)
    );

    ll_fifo_drain_arbiter #(.WIDTH(4), .NUM_FIFOS(3)) dut3 (
        .clk(clk), .rst(rst), .empty(empty3), .data_out(data3), .mask(mask3),
        .pop(pop3), .pop_sel(sel3), .out_valid(valid3), .out_ready(ready3),
        .out_data(out_data3), .out_qid(qid3), .pop_total(total3)
    );

    assign data3 = {2'b00, sel3};

    // ---------------- queue environment (stands in for linked_list_fifo)
    logic [3:0] mem [NF][64];
    int hd [NF];
    int tl [NF];

    always_comb begin
        for (int i = 0; i < NF; i++) empty[i] = (hd[i] == tl[i]);
    end
    assign data_out = mem[pop_sel][hd[pop_sel][5:0]];

    // ---------------- reference model
    typedef struct {int qid; int data;} ent_t;
    ent_t m_q[$];
    int   m_last  = NF - 1;
    int   m_total = 0;
    int   p_log[$];
    int   d_log[$];
    int   d_cyc[$];
    int   cyc = 0;
    bit   e_pop = 1'b0, e_deq = 1'b0, s_pop = 1'b0;
    int   e_sel = 0, e_word = 0, s_sel = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int plog(input int i);
        return (i < p_log.size()) ? p_log[i] : -1;
    endfunction

    // Compare process: predict this cycle's outputs from the model and check.
    always @(negedge clk) begin
        if (rst) begin
            e_pop = 1'b0;
            e_deq = 1'b0;
            s_pop = 1'b0;
        end else begin
            e_pop = 1'b0;
            e_sel = 0;
            for (int k = 1; k <= NF; k++) begin
                int idx;
                idx = (m_last + k) % NF;
                if (!e_pop && tl[idx] != hd[idx] && mask[idx]) begin
                    e_pop = 1'b1;
                    e_sel = idx;
                end
            end
            if (m_q.size() >= 2) e_pop = 1'b0;
            e_word = int'(mem[e_sel][hd[e_sel][5:0]]);
            e_deq  = (m_q.size() != 0) && out_ready;
            chk("pop", pop, e_pop);
            if (e_pop) chk("pop_sel", pop_sel, e_sel);
            chk("out_valid", out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("out_data", out_data, m_q[0].data);
                chk("out_qid", out_qid, m_q[0].qid);
            end
            chk("pop_total", pop_total, m_total & 32'hffff);
            s_pop = pop;
            s_sel = int'(pop_sel);
        end
    end

    // Clock-edge update of environment queues and reference model.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NF; i++) hd[i] <= tl[i];
            m_q.delete();
            m_last  <= NF - 1;
            m_total <= 0;
        end else begin
            cyc <= cyc + 1;
            if (s_pop) hd[s_sel] <= hd[s_sel] + 1;
            if (e_deq) begin
                d_log.push_back(m_q[0].data);
                d_cyc.push_back(cyc);
                void'(m_q.pop_front());
            end
            if (e_pop) begin
                m_q.push_back('{e_sel, e_word});
                m_last  <= e_sel;
                m_total <= m_total + 1;
                p_log.push_back(e_sel);
            end
        end
    end

    task automatic push(input int q, input logic [3:0] d);
        mem[q][tl[q][5:0]] = d;
        tl[q] = tl[q] + 1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int exp4 [5] = '{1, 4, 2, 5, 3};
    int exp3 [4] = '{0, 2, 0, 2};

    initial begin
        int base, dbase, cnt, found;
        mask = 4'hF; out_ready = 1'b1;
        empty3 = 3'b111; mask3 = 3'b111; ready3 = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state, all queues empty
        for (int i = 0; i < 10; i++) begin
            #3;
            chk("rst_pop", pop, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_total", pop_total, 0);
            @(posedge clk); #1;
        end
        chk("rst_data", out_data, 0);
        chk("rst_qid", out_qid, 0);

        // NUM_FIFOS=3: wrap from 2 to 0, never code 3
        empty3 = 3'b011;
        #3;
        chk("n3_pop", pop3, 1);
        chk("n3_first", sel3, 2);
        @(posedge clk); #1;
        empty3 = 3'b010;
        for (int k = 0; k < 4; k++) begin
            #3;
            chk("n3_seq", sel3, exp3[k]);
            chk("n3_legal", sel3 < 2'd3, 1);
            @(posedge clk); #1;
        end
        empty3 = 3'b111;
        step(3);

        // queues 0..3 with 2 words each: strict rotation
        base = p_log.size();
        for (int q = 0; q < NF; q++) begin
            push(q, 4'(q * 2 + 1));
            push(q, 4'(q * 2 + 2));
        end
        step(12);
        chk("rr_count", p_log.size() - base, 8);
        for (int k = 0; k < 8; k++) chk("rr_order", plog(base + k), k % 4);
        chk("rr_total", pop_total, 8);
        chk("rr_model_total", m_total, 8);

        // only queue 2 after grant to 3: search wraps
        base = p_log.size();
        push(2, 4'h9);
        step(4);
        chk("wrap_sel", plog(base), 2);

        // backpressure with 5 words queued
        out_ready = 1'b0;
        base = p_log.size();
        push(0, 4'h1); push(0, 4'h2); push(0, 4'h3);
        push(1, 4'h4); push(1, 4'h5);
        step(6);
        chk("bp_pops", p_log.size() - base, 2);
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("bp_hold_data", out_data, 4'h1);
            chk("bp_no_pop", pop, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        dbase = d_log.size();
        step(8);
        chk("bp_deliv", d_log.size() - dbase, 5);
        for (int k = 0; k < 5; k++) begin
            chk("bp_order", (dbase + k < d_log.size()) ? d_log[dbase + k] : -1, exp4[k]);
            if (dbase + k < d_cyc.size())
                chk("bp_b2b", d_cyc[dbase + k] - d_cyc[dbase], k);
        end

        // masking of queue 2
        mask = 4'b1011;
        base = p_log.size();
        for (int k = 0; k < 4; k++) begin
            push(0, 4'(k)); push(1, 4'(k + 4)); push(3, 4'(k + 8));
        end
        push(2, 4'hA); push(2, 4'hB); push(2, 4'hC);
        step(6);
        cnt = 0;
        for (int k = base; k < p_log.size(); k++) if (p_log[k] == 2) cnt++;
        chk("mask_skip", cnt, 0);
        chk("mask_pops", p_log.size() - base, 6);
        mask = 4'hF;
        base = p_log.size();
        step(4);
        found = -1;
        for (int k = 0; k < 4; k++) if (found < 0 && plog(base + k) == 2) found = k;
        chk("mask_grant", (found >= 0) && (found < 4), 1);
        step(20);

        // reset with buffer full
        out_ready = 1'b0;
        push(0, 4'h6); push(0, 4'h7);
        step(4);
        #3;
        chk("full_valid", out_valid, 1);
        chk("full_nopop", pop, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_total", pop_total, 0);
        chk("arst_data", out_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        base = p_log.size();
        for (int q = 0; q < NF; q++) push(q, 4'(q + 12));
        step(4);
        chk("arst_first", plog(base), 0);
        step(4);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int q = 0; q < NF; q++)
                if ($urandom_range(0, 9) < 3 && (tl[q] - hd[q]) < 32) push(q, 4'($urandom));
            if (c % 16 == 0) mask = 4'($urandom) | 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        mask = 4'hF;
        out_ready = 1'b1;
        step(150);
        chk("drain_valid", out_valid, 0);
        chk("drain_empty", empty, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
